// File: rtl/sb_access_arbiter.sv
// sb_access_arbiter: shares one system-bus word port between the debugger and the core,
// with halted-priority / round-robin grant, misalignment rejection and a bus timeout.
`default_nettype none

module sb_access_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          core_halted,
  output logic [AW-1:0] sb_addr,
  output logic [DW-1:0] sb_wdata,
  output logic          sb_read,
  output logic          sb_write,
  input  logic [DW-1:0] sb_rdata,
  input  logic          sb_ready,
  output logic          err,
  output logic          owner,
  output logic          busy
);

  localparam int            CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          misaligned;
  logic          cur_we;

  logic          win_dbg;
  logic          win_core;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_misaligned;

  logic          timed_out;
  logic          done;
  logic          done_err;
  logic [DW-1:0] done_data;

  // owner=1 (core granted last) hands a contested grant to dbg
  always_comb begin
    win_dbg  = 1'b0;
    win_core = 1'b0;
    if (core_halted) begin
      win_dbg  = dbg_req;
      win_core = !dbg_req && core_req;
    end else if (dbg_req && core_req) begin
      win_dbg  = owner;
      win_core = !owner;
    end else begin
      win_dbg  = dbg_req;
      win_core = core_req;
    end
  end

  assign sel_we         = win_core ? core_we    : dbg_we;
  assign sel_addr       = win_core ? core_addr  : dbg_addr;
  assign sel_wdata      = win_core ? core_wdata : dbg_wdata;
  assign sel_misaligned = |sel_addr[1:0];

  // sb_ready on the timeout edge still counts as a normal completion
  assign timed_out = (cnt == LAST);
  assign done      = misaligned || sb_ready || timed_out;
  assign done_err  = misaligned || (!sb_ready && timed_out);
  assign done_data = (done_err || cur_we) ? '0 : sb_rdata;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      misaligned  <= 1'b0;
      cur_we      <= 1'b0;
      owner       <= 1'b1;
      dbg_gnt     <= 1'b0;
      core_gnt    <= 1'b0;
      dbg_rvalid  <= 1'b0;
      core_rvalid <= 1'b0;
      dbg_rdata   <= '0;
      core_rdata  <= '0;
      sb_addr     <= '0;
      sb_wdata    <= '0;
      sb_read     <= 1'b0;
      sb_write    <= 1'b0;
      err         <= 1'b0;
    end else begin
      dbg_gnt     <= 1'b0;
      core_gnt    <= 1'b0;
      dbg_rvalid  <= 1'b0;
      core_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (win_dbg || win_core) begin
            state      <= ACCESS;
            owner      <= win_core;
            dbg_gnt    <= win_dbg;
            core_gnt   <= win_core;
            cur_we     <= sel_we;
            misaligned <= sel_misaligned;
            sb_addr    <= sel_addr;
            sb_wdata   <= sel_wdata;
            sb_read    <= !sel_misaligned && !sel_we;
            sb_write   <= !sel_misaligned && sel_we;
            cnt        <= '0;
          end
        end
        ACCESS: begin
          if (done) begin
            state    <= RESP;
            sb_read  <= 1'b0;
            sb_write <= 1'b0;
            err      <= done_err;
            if (owner) begin
              core_rvalid <= 1'b1;
              core_rdata  <= done_data;
            end else begin
              dbg_rvalid <= 1'b1;
              dbg_rdata  <= done_data;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          err   <= 1'b0;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sb_access_arbiter.sv
// tb_sb_access_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a transaction-timeline model of the arbiter.
`default_nettype none

module tb_sb_access_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          core_req = 1'b0, core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          core_gnt, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          core_halted = 1'b0;
  logic [AW-1:0] sb_addr;
  logic [DW-1:0] sb_wdata;
  logic          sb_read, sb_write;
  logic [DW-1:0] sb_rdata = '0;
  logic          sb_ready = 1'b0;
  logic          err, owner, busy;

  always #5 clk = ~clk;

  sb_access_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .core_halted(core_halted),
    .sb_addr(sb_addr), .sb_wdata(sb_wdata), .sb_read(sb_read), .sb_write(sb_write),
    .sb_rdata(sb_rdata), .sb_ready(sb_ready),
    .err(err), .owner(owner), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: condition not met at %0t", name, $time);
  endtask

  // Transaction timeline model: a grant at an idle edge starts a transaction whose
  // cycles are numbered by age (1 = gnt cycle). Strobes cover ages 1..S, the response
  // pulse is age S+1, and the cycle after that is idle again.
  bit            m_in_txn = 1'b0;
  int            m_age = 0, m_S = 0, m_L = 0;
  bit            m_who = 1'b0, m_misal = 1'b0, m_we = 1'b0, m_err = 1'b0, m_owner = 1'b1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_bdata = '0;
  logic [DW-1:0] m_rd0 = '0, m_rd1 = '0;

  int            lat_mode = -1;       // forced ready latency in strobe cycles; 0 = never
  bit            use_forced = 1'b0;
  logic [DW-1:0] forced_data = '0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_in_txn = 1'b0;
      m_owner  = 1'b1;
      m_rd0    = '0;
      m_rd1    = '0;
    end else if (m_in_txn) begin
      if (m_age == m_S + 1) begin
        m_in_txn = 1'b0;
      end else begin
        m_age++;
        if (m_age == m_S + 1) begin
          if (m_who) m_rd1 = (m_err || m_we) ? '0 : m_bdata;
          else       m_rd0 = (m_err || m_we) ? '0 : m_bdata;
        end
      end
    end else if (dbg_req || core_req) begin
      if (core_halted)             m_who = !dbg_req;
      else if (dbg_req && core_req) m_who = !m_owner;
      else                          m_who = core_req;
      m_owner = m_who;
      m_we    = m_who ? core_we    : dbg_we;
      m_addr  = m_who ? core_addr  : dbg_addr;
      m_wdata = m_who ? core_wdata : dbg_wdata;
      m_misal = (m_addr[1:0] != 2'b00);
      if (lat_mode >= 0) m_L = lat_mode;
      else begin
        int r;
        r   = int'($urandom_range(0, 19));
        m_L = (r == 0) ? 0 : (r == 1) ? TIMEOUT : int'($urandom_range(1, 4));
      end
      m_bdata  = use_forced ? forced_data : DW'($urandom);
      m_S      = m_misal ? 1 : ((m_L != 0 && m_L <= TIMEOUT) ? m_L : TIMEOUT);
      m_err    = m_misal || (m_L == 0) || (m_L > TIMEOUT);
      m_age    = 1;
      m_in_txn = 1'b1;
    end
    #1;
    // bus responder: ready exactly on strobe cycle L, noise wherever it must be ignored
    if (reset && m_in_txn && !m_misal && m_age <= m_S) begin
      sb_ready = (m_age == m_L);
      sb_rdata = (m_age == m_L) ? m_bdata : DW'($urandom);
    end else begin
      sb_ready = 1'($urandom_range(0, 1));
      sb_rdata = DW'($urandom);
    end
  end

  int cyc = 0, strobe_total = 0, rv_total = 0, core_act_total = 0;
  int gnt_cyc = 0, rv_cyc = 0;
  bit gnt_log[$];

  initial forever begin
    logic [8:0] e_vec, d_vec;
    bit         e_str, e_rv, e_g;
    @(negedge clk);
    cyc++;
    d_vec = {dbg_gnt, core_gnt, dbg_rvalid, core_rvalid, sb_read, sb_write, err, busy, owner};
    if (!reset) begin
      chk("reset_ctrl", 64'(d_vec), 64'(9'b0_0000_0001));
      chk("reset_data", 64'(|{sb_addr, sb_wdata, dbg_rdata, core_rdata}), 64'(0));
    end else begin
      e_str = m_in_txn && !m_misal && (m_age <= m_S);
      e_rv  = m_in_txn && (m_age == m_S + 1);
      e_g   = m_in_txn && (m_age == 1);
      e_vec = {e_g && !m_who, e_g && m_who, e_rv && !m_who, e_rv && m_who,
               e_str && !m_we, e_str && m_we, e_rv && m_err, m_in_txn, m_owner};
      chk("ctrl{gnt_d,gnt_c,rv_d,rv_c,rd,wr,err,busy,owner}", 64'(d_vec), 64'(e_vec));
      chk("dbg_rdata", 64'(dbg_rdata), 64'(m_rd0));
      chk("core_rdata", 64'(core_rdata), 64'(m_rd1));
      if (e_str) begin
        chk("sb_addr", 64'(sb_addr), 64'(m_addr));
        if (m_we) chk("sb_wdata", 64'(sb_wdata), 64'(m_wdata));
      end
    end
    if (sb_read || sb_write) strobe_total++;
    if (dbg_gnt) gnt_log.push_back(1'b0);
    if (core_gnt) gnt_log.push_back(1'b1);
    if (dbg_gnt || core_gnt) gnt_cyc = cyc;
    if (dbg_rvalid || core_rvalid) begin rv_total++; rv_cyc = cyc; end
    if (core_gnt || core_rvalid) core_act_total++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      0: return dbg_gnt;
      1: return core_gnt;
      2: return dbg_rvalid;
      3: return core_rvalid;
      4: return !busy;
      default: return dbg_gnt || core_gnt;
    endcase
  endfunction

  task automatic wait_until(input string name, input int sel, input int budget);
    int n = 0;
    while (!sig(sel)) begin
      tick();
      n++;
      if (n > budget) begin
        fail({name, "_timeout"});
        return;
      end
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 255)) << 2;
    if ($urandom_range(0, 5) == 0) a = a | AW'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  bit exp_rr[4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
  bit exp_halt[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int s_str, s_core, s_rv, g0;
    tick();
    tick();
    chk("reset_owner", 64'(owner), 64'(1));
    chk("reset_busy", 64'(busy), 64'(0));
    reset = 1'b1;
    tick();

    // dbg read of 0x10, bus answers on the 2nd strobe cycle
    lat_mode = 2; use_forced = 1'b1; forced_data = 32'hDEADBEEF;
    s_str = strobe_total; s_core = core_act_total;
    dbg_we = 1'b0; dbg_addr = 32'h10; dbg_req = 1'b1;
    wait_until("t1_gnt", 0, 10);
    dbg_req = 1'b0;
    wait_until("t1_rvalid", 2, 20);
    chk("t1_rdata", 64'(dbg_rdata), 64'(32'hDEADBEEF));
    chk("t1_err", 64'(err), 64'(0));
    chk("t1_strobe_cycles", 64'(strobe_total - s_str), 64'(2));
    chk("t1_core_idle", 64'(core_act_total - s_core), 64'(0));
    use_forced = 1'b0;

    // contested round-robin after reset: dbg, core, dbg, core
    do_reset();
    lat_mode = 1; core_halted = 1'b0;
    g0 = gnt_log.size();
    dbg_req = 1'b1; core_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_until("t2_gnt", 5, 20);
      tick();
    end
    dbg_req = 1'b0; core_req = 1'b0;
    wait_until("t2_idle", 4, 20);
    if (gnt_log.size() >= g0 + 4) begin
      for (int i = 0; i < 4; i++) chk("t2_grant_order", 64'(gnt_log[g0 + i]), 64'(exp_rr[i]));
    end else fail("t2_grant_count");
    chk("t2_owner", 64'(owner), 64'(1));

    // halted core: dbg keeps winning until it drops its request
    core_halted = 1'b1;
    g0 = gnt_log.size();
    dbg_req = 1'b1; core_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_until("t3_gnt", 5, 20);
      tick();
    end
    dbg_req = 1'b0;
    wait_until("t3_core_gnt", 5, 20);
    tick();
    core_req = 1'b0;
    wait_until("t3_idle", 4, 20);
    if (gnt_log.size() >= g0 + 4) begin
      for (int i = 0; i < 4; i++) chk("t3_grant_order", 64'(gnt_log[g0 + i]), 64'(exp_halt[i]));
    end else fail("t3_grant_count");
    core_halted = 1'b0;

    // core write that never gets sb_ready
    lat_mode = 0;
    s_str = strobe_total;
    core_we = 1'b1; core_addr = 32'h20; core_wdata = 32'h12345678; core_req = 1'b1;
    wait_until("t4_gnt", 1, 10);
    core_req = 1'b0;
    wait_until("t4_rvalid", 3, TIMEOUT + 10);
    chk("t4_strobe_cycles", 64'(strobe_total - s_str), 64'(TIMEOUT));
    chk("t4_err", 64'(err), 64'(1));
    chk("t4_rdata", 64'(core_rdata), 64'(0));
    tick();
    chk("t4_busy_after", 64'(busy), 64'(0));

    // misaligned dbg read
    lat_mode = 1;
    s_str = strobe_total;
    dbg_we = 1'b0; dbg_addr = 32'h13; dbg_req = 1'b1;
    wait_until("t5_gnt", 0, 10);
    dbg_req = 1'b0;
    wait_until("t5_rvalid", 2, 10);
    chk("t5_gnt_to_rvalid", 64'(rv_cyc - gnt_cyc), 64'(1));
    chk("t5_err", 64'(err), 64'(1));
    chk("t5_no_strobe", 64'(strobe_total - s_str), 64'(0));
    chk("t5_rdata", 64'(dbg_rdata), 64'(0));
    tick();

    // reset during the 3rd wait cycle of an access
    lat_mode = 0;
    dbg_we = 1'b0; dbg_addr = 32'h40; dbg_req = 1'b1;
    wait_until("t6_gnt", 0, 10);
    dbg_req = 1'b0;
    tick();
    tick();
    s_rv = rv_total;
    reset = 1'b0;
    #1;
    chk("t6_strobe_drop", 64'({sb_read, sb_write}), 64'(0));
    chk("t6_busy_drop", 64'(busy), 64'(0));
    tick();
    tick();
    lat_mode = 1;
    dbg_req = 1'b1; core_req = 1'b1;
    reset = 1'b1;
    wait_until("t6_regrant", 5, 10);
    chk("t6_no_rvalid", 64'(rv_total - s_rv), 64'(0));
    if (gnt_log.size() > 0) chk("t6_first_grant", 64'(gnt_log[gnt_log.size() - 1]), 64'(0));
    else fail("t6_grant_missing");
    dbg_req = 1'b0; core_req = 1'b0;
    wait_until("t6_idle", 4, 20);

    // randomized traffic
    lat_mode = -1;
    for (int i = 0; i < 2500; i++) begin
      tick();
      if (dbg_req && dbg_gnt) dbg_req = 1'b0;
      else if (!dbg_req && $urandom_range(0, 3) == 0) begin
        dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = rand_addr(); dbg_wdata = DW'($urandom);
      end
      if (core_req && core_gnt) core_req = 1'b0;
      else if (!core_req && $urandom_range(0, 3) == 0) begin
        core_req = 1'b1; core_we = 1'($urandom_range(0, 1));
        core_addr = rand_addr(); core_wdata = DW'($urandom);
      end
      if ($urandom_range(0, 15) == 0) core_halted = 1'($urandom_range(0, 1));
    end
    dbg_req = 1'b0; core_req = 1'b0;
    tick();
    wait_until("final_idle", 4, TIMEOUT + 10);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/sb_access_arbiter.md
Name: sb_access_arbiter

Overview:
- Shares the single system-bus memory port between two requesters: the debug module's system-bus access path (dbg) and the core's load/store path (core).
- Grants one word transaction at a time and drives sb_addr/sb_wdata/sb_read/sb_write.
- Holds the strobes until sb_ready, then returns read data and status to the owner.
- Sits between the DMI/core and the system_bus_memory instance; includes a timeout so a stuck bus never hangs the debugger.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 64, max cycles in ACCESS waiting for sb_ready before abort (≥2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous reset, active-low (asserted at 0).
- dbg_req  in  1  debugger request; held until dbg_gnt.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  AW  byte address.
- dbg_wdata  in  DW  write data.
- dbg_gnt  out  1  one-cycle pulse: request accepted.
- dbg_rvalid  out  1  one-cycle pulse: transaction complete.
- dbg_rdata  out  DW  read data, valid with dbg_rvalid.
- core_req, core_we, core_addr, core_wdata  in  1/1/AW/DW  same semantics as dbg_*.
- core_gnt, core_rvalid  out  1  same semantics as dbg_*.
- core_rdata  out  DW  same semantics as dbg_rdata.
- core_halted  in  1  core is halted; debugger gets strict priority.
- sb_addr  out  AW  bus address.
- sb_wdata  out  DW  bus write data.
- sb_read  out  1  read strobe.
- sb_write  out  1  write strobe.
- sb_rdata  in  DW  bus read data.
- sb_ready  in  1  bus completion.
- err  out  1  status, valid with the rvalid pulse: 1 = timeout or misaligned.
- owner  out  1  0 = dbg, 1 = core; last/current grantee.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (reset=0, immediate):
  - State = IDLE.
  - All outputs 0: strobes, gnt, rvalid, err, busy, sb_addr, sb_wdata, rdata.
  - owner = 1, so the first contested grant goes to dbg.
  - Timeout counter = 0.
- IDLE, arbitration on a sampled edge:
  - core_halted=1: dbg wins if dbg_req.
  - core_halted=0 and both requesting: round-robin; the grant goes to the requester that is not owner.
  - Single requester: it wins.
- On the winning edge:
  - Latch we/addr/wdata; update owner.
  - Pulse X_gnt in the next cycle.
- Misaligned address (addr[1:0] != 0):
  - No bus strobe; go to RESP with err=1, rdata=0.
- Aligned address:
  - Go to ACCESS.
  - sb_read (we=0) or sb_write (we=1) asserts in the same cycle as X_gnt.
  - sb_addr/sb_wdata are driven from latched values.
- ACCESS:
  - Strobes and address stay stable every cycle until sb_ready=1 is sampled.
  - On sb_ready: capture sb_rdata (0 for writes); go to RESP; deassert strobes next cycle.
  - Counter increments each cycle in ACCESS.
  - If the counter reaches TIMEOUT-1 without sb_ready: drop strobes; go to RESP with err=1, rdata=0.
  - sb_ready arriving on the same edge as timeout wins: normal completion, err=0.
- RESP:
  - Exactly one cycle.
  - X_rvalid=1; X_rdata and err valid; other requester's rvalid stays 0.
  - Return to IDLE; clear the counter.
  - rdata holds its value until the next completion; err returns to 0 after the pulse.
- Latency:
  - req sampled at edge N → gnt and strobe during cycle N+1.
  - sb_ready sampled at edge M → rvalid during cycle M+1.
  - Next grant is earliest at edge M+2; at most one outstanding transaction.
- Requests while busy are ignored; requesters keep req high until gnt.
- core_halted changes only take effect at IDLE arbitration; an in-flight core access completes normally.
- sb_ready while in IDLE/RESP is ignored.
- Reset mid-ACCESS:
  - Strobes drop immediately; no rvalid is issued.
  - After release, the arbiter restarts from IDLE with owner=1.

Test Plan:
- dbg read, addr 0x10, bus returns 0xDEADBEEF with sb_ready 2 cycles after strobe → dbg_gnt 1 cycle, sb_read held 2 cycles, dbg_rvalid with 0xDEADBEEF, err=0, core_* idle.
- dbg_req and core_req high together for 4 transactions, core_halted=0 → grant order dbg, core, dbg, core; owner toggles each grant.
- Same as above with core_halted=1 → all grants go to dbg while dbg_req is high; core is granted only after dbg_req drops.
- core write addr 0x20, data 0x12345678, sb_ready never asserted, TIMEOUT=64 → sb_write high exactly 64 cycles, core_rvalid with err=1, rdata=0, busy low after.
- dbg read addr 0x13 → no sb_read or sb_write, dbg_gnt then dbg_rvalid with err=1 one cycle later.
- reset=0 asserted mid-ACCESS (3rd wait cycle) → strobes and busy 0 within the same cycle, no rvalid; after release, a contested request is granted to dbg.
